// File: rtl/imm_split.sv
// Splits a 32-bit constant or branch byte-offset into one or two 16-bit (imm, eop)
// beats for the immediate extender, choosing the cheapest extender encoding.
`timescale 1ns/1ps
module imm_split #(
    parameter int CNT_W     = 8,
    parameter bit BRANCH_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_value,
    input  logic             in_kind,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_imm,
    output logic [1:0]       out_eop,
    output logic             out_last,
    output logic             out_err,
    output logic [CNT_W-1:0] split_cnt
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BEAT1 = 2'd1;
    localparam logic [1:0] BEAT2 = 2'd2;

    localparam logic [1:0] EOP_SEXT  = 2'b00;
    localparam logic [1:0] EOP_ZEXT  = 2'b01;
    localparam logic [1:0] EOP_HI    = 2'b10;
    localparam logic [1:0] EOP_BR    = 2'b11;

    logic [1:0]       state_q, state_d;
    logic [15:0]      imm_q, imm_d;
    logic [15:0]      lo_q, lo_d;
    logic [1:0]       eop_q, eop_d;
    logic             last_q, last_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        hi_sext, hi_zero, lo_zero, br_ok;
    logic [15:0] enc_imm;
    logic [1:0]  enc_eop;
    logic        enc_two, enc_err;
    logic        accept, consume;

    assign hi_sext = (&in_value[31:15]) | ~(|in_value[31:15]);
    assign hi_zero = ~(|in_value[31:16]);
    assign lo_zero = ~(|in_value[15:0]);
    assign br_ok   = BRANCH_EN && (in_value[1:0] == 2'b00) &&
                     ((&in_value[31:17]) | ~(|in_value[31:17]));

    // Encoding priority for constants: sign-ext, zero-ext, upper-only, then lui+ori pair.
    always_comb begin
        enc_imm = 16'h0000;
        enc_eop = EOP_SEXT;
        enc_two = 1'b0;
        enc_err = 1'b0;
        if (in_kind) begin
            enc_eop = EOP_BR;
            if (br_ok) begin
                enc_imm = in_value[17:2];
            end else begin
                enc_err = 1'b1;
            end
        end else if (hi_sext) begin
            enc_imm = in_value[15:0];
            enc_eop = EOP_SEXT;
        end else if (hi_zero) begin
            enc_imm = in_value[15:0];
            enc_eop = EOP_ZEXT;
        end else if (lo_zero) begin
            enc_imm = in_value[31:16];
            enc_eop = EOP_HI;
        end else begin
            enc_imm = in_value[31:16];
            enc_eop = EOP_HI;
            enc_two = 1'b1;
        end
    end

    assign accept  = in_valid && (state_q == IDLE);
    assign consume = out_ready && (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        imm_d   = imm_q;
        lo_d    = lo_q;
        eop_d   = eop_q;
        last_d  = last_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BEAT1;
                    imm_d   = enc_imm;
                    lo_d    = in_value[15:0];
                    eop_d   = enc_eop;
                    last_d  = ~enc_two;
                    err_d   = enc_err;
                    if (enc_two && (cnt_q != {CNT_W{1'b1}})) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            BEAT1: begin
                if (consume) begin
                    if (!last_q) begin
                        state_d = BEAT2;
                        imm_d   = lo_q;
                        eop_d   = EOP_ZEXT;
                        last_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                        imm_d   = 16'h0000;
                        eop_d   = EOP_SEXT;
                        last_d  = 1'b0;
                        err_d   = 1'b0;
                    end
                end
            end
            BEAT2: begin
                if (consume) begin
                    state_d = IDLE;
                    imm_d   = 16'h0000;
                    eop_d   = EOP_SEXT;
                    last_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                imm_d   = 16'h0000;
                eop_d   = EOP_SEXT;
                last_d  = 1'b0;
                err_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            imm_q   <= 16'h0000;
            lo_q    <= 16'h0000;
            eop_q   <= EOP_SEXT;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            imm_q   <= imm_d;
            lo_q    <= lo_d;
            eop_q   <= eop_d;
            last_q  <= last_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q != IDLE);
    assign out_imm   = imm_q;
    assign out_eop   = eop_q;
    assign out_last  = last_q;
    assign out_err   = err_q;
    assign split_cnt = cnt_q;

endmodule

// File: tb/tb_imm_split.sv
// Directed-vector bench for imm_split: single/two-beat encodings, branch offsets,
// back-pressure, asynchronous reset mid-request and counter saturation.
`timescale 1ns/1ps
module tb_imm_split;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_value = 32'h0;
    logic        in_kind = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_imm;
    logic [1:0]  out_eop;
    logic        out_last;
    logic        out_err;
    logic [7:0]  split_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imm_split #(.CNT_W(8), .BRANCH_EN(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_value  (in_value),
        .in_kind   (in_kind),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm),
        .out_eop   (out_eop),
        .out_last  (out_last),
        .out_err   (out_err),
        .split_cnt (split_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called #1 after a clock edge with the DUT idle; ends #1 after the edge that returns it to IDLE.
    task automatic do_req(input logic [31:0] v, input logic kind,
                          input logic [15:0] imm1, input logic [1:0] eop1,
                          input logic err, input logic two, input logic [15:0] imm2);
        $display("req value=%08h kind=%0d two=%0d", v, kind, two);
        check("idle_ready", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_value = v;
        in_kind  = kind;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_value = ~v;
        in_kind  = ~kind;
        check("b1_valid", {31'b0, out_valid}, 32'd1);
        check("b1_ready", {31'b0, in_ready}, 32'd0);
        check("b1_imm", {16'b0, out_imm}, {16'b0, imm1});
        check("b1_eop", {30'b0, out_eop}, {30'b0, eop1});
        check("b1_last", {31'b0, out_last}, {31'b0, ~two});
        check("b1_err", {31'b0, out_err}, {31'b0, err});
        @(posedge clk); #1;
        if (two) begin
            check("b2_valid", {31'b0, out_valid}, 32'd1);
            check("b2_imm", {16'b0, out_imm}, {16'b0, imm2});
            check("b2_eop", {30'b0, out_eop}, 32'd1);
            check("b2_last", {31'b0, out_last}, 32'd1);
            check("b2_err", {31'b0, out_err}, 32'd0);
            @(posedge clk); #1;
        end
        check("end_valid", {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        #12;
        check("rst_ready", {31'b0, in_ready}, 32'd1);
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_imm", {16'b0, out_imm}, 32'd0);
        check("rst_eop", {30'b0, out_eop}, 32'd0);
        check("rst_last", {31'b0, out_last}, 32'd0);
        check("rst_err", {31'b0, out_err}, 32'd0);
        check("rst_cnt", {24'b0, split_cnt}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Constant encodings
        do_req(32'h0000_7FFF, 1'b0, 16'h7FFF, 2'b00, 1'b0, 1'b0, 16'h0);
        do_req(32'h0000_8000, 1'b0, 16'h8000, 2'b01, 1'b0, 1'b0, 16'h0);
        do_req(32'hFFFF_8000, 1'b0, 16'h8000, 2'b00, 1'b0, 1'b0, 16'h0);
        do_req(32'h1234_0000, 1'b0, 16'h1234, 2'b10, 1'b0, 1'b0, 16'h0);
        check("cnt_before_split", {24'b0, split_cnt}, 32'd0);
        do_req(32'h1234_5678, 1'b0, 16'h1234, 2'b10, 1'b0, 1'b1, 16'h5678);
        check("cnt_after_split", {24'b0, split_cnt}, 32'd1);

        // Branch offsets
        do_req(32'hFFFF_FFFC, 1'b1, 16'hFFFF, 2'b11, 1'b0, 1'b0, 16'h0);
        do_req(32'h0001_FFFC, 1'b1, 16'h7FFF, 2'b11, 1'b0, 1'b0, 16'h0);
        do_req(32'h0002_0000, 1'b1, 16'h0000, 2'b11, 1'b1, 1'b0, 16'h0);
        do_req(32'h0000_0006, 1'b1, 16'h0000, 2'b11, 1'b1, 1'b0, 16'h0);
        check("cnt_after_branch", {24'b0, split_cnt}, 32'd1);

        // Back-pressure on both beats of a split request
        $display("req value=%08h kind=0 stalled", 32'hABCD_1357);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_value  = 32'hABCD_1357;
        in_kind   = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_value = 32'h0;
        for (int i = 0; i < 5; i++) begin
            check("stall1_valid", {31'b0, out_valid}, 32'd1);
            check("stall1_ready", {31'b0, in_ready}, 32'd0);
            check("stall1_imm", {16'b0, out_imm}, 32'h0000_ABCD);
            check("stall1_eop", {30'b0, out_eop}, 32'd2);
            check("stall1_last", {31'b0, out_last}, 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall2_valid", {31'b0, out_valid}, 32'd1);
            check("stall2_ready", {31'b0, in_ready}, 32'd0);
            check("stall2_imm", {16'b0, out_imm}, 32'h0000_1357);
            check("stall2_eop", {30'b0, out_eop}, 32'd1);
            check("stall2_last", {31'b0, out_last}, 32'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("stall_done", {31'b0, out_valid}, 32'd0);
        check("cnt_after_stall", {24'b0, split_cnt}, 32'd2);

        // Asynchronous reset while the second beat is pending
        $display("req value=%08h kind=0 reset in beat2", 32'h5555_AAAA);
        in_valid = 1'b1;
        in_value = 32'h5555_AAAA;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_b2_imm", {16'b0, out_imm}, 32'h0000_AAAA);
        reset = 1'b0;
        #1;
        check("arst_valid", {31'b0, out_valid}, 32'd0);
        check("arst_cnt", {24'b0, split_cnt}, 32'd0);
        #2;
        reset = 1'b1;
        @(posedge clk); #1;
        check("arst_ready", {31'b0, in_ready}, 32'd1);
        check("arst_idle_valid", {31'b0, out_valid}, 32'd0);

        // Counter saturation over 300 split requests
        for (int i = 0; i < 300; i++) begin
            in_valid = 1'b1;
            in_value = 32'h7654_3210 + i;
            in_kind  = 1'b0;
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(posedge clk); #1;
            @(posedge clk); #1;
            if (i == 9) check("cnt_10", {24'b0, split_cnt}, 32'd10);
        end
        $display("req x300 split requests done");
        check("cnt_sat", {24'b0, split_cnt}, 32'd255);
        do_req(32'h0BAD_F00D, 1'b0, 16'h0BAD, 2'b10, 1'b0, 1'b1, 16'hF00D);
        check("cnt_hold", {24'b0, split_cnt}, 32'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
